crc2bit_framer: RTL and testbench
=================================

# crc2bit_framer

Byte-to-dibit framer that sits directly upstream of the 2-bit CRC-6 engine's consumer path. It accepts bytes on a valid/ready stream and serialises each byte MSB-dibit first onto a 2-bit output stream. It runs its own CRC-6 (polynomial 1+x+x^2+x^3+x^5+x^6, seed all-ones, 2 bits/step) over the emitted data dibits. On the last byte of a frame it appends the 6-bit CRC as three trailing dibits.

## Interface
- No parameters; widths fixed (byte in, dibit out, 6-bit CRC).
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- s_data  in  8  input byte.
- s_valid  in  1  s_data/s_last valid.
- s_last  in  1  byte is last of frame.
- s_ready  out  1  framer accepts byte this cycle.
- m_dibit  out  2  output dibit; [1] is the earlier (more significant) bit.
- m_valid  out  1  m_dibit valid.
- m_last  out  1  final dibit of frame (last CRC dibit).
- m_ready  in  1  downstream accepts dibit.
- frame_crc  out  6  CRC of most recent completed frame.
- frame_done  out  1  one-cycle pulse when last CRC dibit is accepted.

## Operation
- States: IDLE, DATA, CRC. Registers:
  - byte_q[7:0]
  - last_q
  - cnt[1:0] (dibit index)
  - crc_q[5:0]
  - state
- Handshakes:
  - Input transfer = s_valid & s_ready.
  - Output transfer = m_valid & m_ready.
- IDLE:
  - s_ready=1, m_valid=0, crc_q held at 6'h3F.
  - On input transfer: load byte_q and last_q, set cnt=0, go to DATA.
- DATA:
  - m_valid=1, m_dibit=byte_q[7-2*cnt -: 2] (cnt 0 gives [7:6], cnt 3 gives [1:0]).
  - On output transfer: crc_q <= next(crc_q, m_dibit), cnt <= cnt+1.
  - On output transfer with cnt==3 and last_q==0: the next byte may be accepted in the same cycle. Set s_ready = (cnt==3) & m_ready & ~last_q. If the next byte is accepted, reload byte_q, set cnt=0 and stay in DATA. Otherwise go to IDLE-wait (state IDLE with crc_q NOT reseeded; see below).
  - On output transfer with cnt==3 and last_q==1: go to CRC, cnt=0, and latch the final crc into crc_q.
- CRC:
  - s_ready=0, m_valid=1.
  - m_dibit = crc_q[5:4], then [3:2], then [1:0] for cnt 0, 1, 2. No inversion, no CRC update.
  - m_last=1 when cnt==2.
  - On output transfer at cnt==2: frame_crc <= crc_q, frame_done pulses, crc_q <= 6'h3F, go to IDLE.
- Mid-frame gap: a separate flag in_frame=1 marks that a frame has started and its last byte has not yet been seen. IDLE entered with in_frame=1 keeps crc_q. crc_q is reseeded only at frame end and at reset.
- CRC step next(q,d), with d=dibit:
  - c0=q4^q5^d0^d1
  - c1=q4^d0
  - c2=q0^q4^d0
  - c3=q1^q4^d0
  - c4=q2^q5^d1
  - c5=q3^q4^q5^d0^d1
- Frames are ≥1 byte by construction. An empty frame is not representable.
- s_data/s_last are ignored when s_ready=0. m_dibit is don't-care when m_valid=0.

## Timing
- Reset values:
  - state=IDLE, in_frame=0, crc_q=6'h3F, cnt=0
  - frame_crc=6'h3F, frame_done=0
  - m_valid=0, m_last=0, s_ready=1
- Latency: the first dibit appears on m_dibit the cycle after the input transfer. A byte occupies 4 output beats; the CRC trailer occupies 3 beats.
- Throughput with m_ready held high:
  - Back-to-back bytes of one frame stream with zero bubbles.
  - A frame of N bytes emits 4N+3 consecutive beats.
  - The next frame's first byte can be accepted the cycle after frame_done, so there is 1 idle beat between frames.
- Backpressure: while m_valid=1 and m_ready=0, m_dibit, m_last, cnt and crc_q hold.
- s_ready depends combinationally on m_ready. No other input-to-output combinational path exists; m_* and frame_* are functions of registers only.
- Async rst mid-frame: all registers return to their reset values immediately. The partial frame is dropped with no trailer and no frame_done.

## Test plan
- Single byte 0x00 with s_last=1, m_ready=1 -> m_dibit 00,00,00,00,11,01,10 with m_last on beat 7; frame_done pulses; frame_crc=6'h36.
- Two-byte frame 0xA5, 0x3C sent back-to-back -> 11 contiguous beats 10,10,01,01,00,11,11,00, then the CRC dibits; frame_crc matches the reference model over 8 data dibits.
- Random m_ready toggling (50%) over a 16-byte frame -> dibit sequence identical to the m_ready=1 run; outputs stable during stalls.
- Gap of 5 cycles between bytes 1 and 2 of one frame (s_valid low) -> CRC equals the no-gap result.
- Two consecutive single-byte 0x00 frames -> both report frame_crc=6'h36 (seed restored between frames).
- rst asserted asynchronously during DATA beat 2 -> m_valid=0 and s_ready=1 immediately; no frame_done; the next 0x00 frame yields 6'h36.

Source files
------------

// File: rtl/crc2bit_framer.sv
// Byte-to-dibit framer: serialises bytes MSB-dibit first and appends a CRC-6
// trailer (poly 1+x+x^2+x^3+x^5+x^6, seed all-ones) on the last byte of a frame.
module crc2bit_framer (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [1:0] m_dibit,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic [5:0] frame_crc,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, DATA, CRC} state_e;

  state_e     state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic       last_q, last_d;
  logic [1:0] cnt_q, cnt_d;
  logic [5:0] crc_q, crc_d;
  logic       in_frame_q, in_frame_d;
  logic [5:0] frame_crc_q, frame_crc_d;
  logic       frame_done_q, frame_done_d;
  logic [1:0] dib;

  function automatic logic [5:0] crc_step(input logic [5:0] q, input logic [1:0] d);
    logic [5:0] c;
    c[0] = q[4] ^ q[5] ^ d[0] ^ d[1];
    c[1] = q[4] ^ d[0];
    c[2] = q[0] ^ q[4] ^ d[0];
    c[3] = q[1] ^ q[4] ^ d[0];
    c[4] = q[2] ^ q[5] ^ d[1];
    c[5] = q[3] ^ q[4] ^ q[5] ^ d[0] ^ d[1];
    return c;
  endfunction

  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    crc_d        = crc_q;
    in_frame_d   = in_frame_q;
    frame_crc_d  = frame_crc_q;
    frame_done_d = 1'b0;
    s_ready      = 1'b0;
    m_valid      = 1'b0;
    m_last       = 1'b0;
    dib          = byte_q[7:6];

    case (state_q)
      IDLE: begin
        s_ready = 1'b1;
        // IDLE between bytes of an open frame keeps the running CRC
        if (!in_frame_q) crc_d = '1;
        if (s_valid) begin
          byte_d     = s_data;
          last_d     = s_last;
          cnt_d      = '0;
          in_frame_d = ~s_last;
          state_d    = DATA;
        end
      end

      DATA: begin
        m_valid = 1'b1;
        case (cnt_q)
          2'd0:    dib = byte_q[7:6];
          2'd1:    dib = byte_q[5:4];
          2'd2:    dib = byte_q[3:2];
          default: dib = byte_q[1:0];
        endcase
        s_ready = (cnt_q == 2'd3) & m_ready & ~last_q;
        if (m_ready) begin
          crc_d = crc_step(crc_q, dib);
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (last_q) begin
              state_d = CRC;
              cnt_d   = '0;
            end else if (s_valid) begin
              byte_d     = s_data;
              last_d     = s_last;
              cnt_d      = '0;
              in_frame_d = ~s_last;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      CRC: begin
        m_valid = 1'b1;
        m_last  = (cnt_q == 2'd2);
        case (cnt_q)
          2'd0:    dib = crc_q[5:4];
          2'd1:    dib = crc_q[3:2];
          default: dib = crc_q[1:0];
        endcase
        if (m_ready) begin
          if (cnt_q == 2'd2) begin
            frame_crc_d  = crc_q;
            frame_done_d = 1'b1;
            crc_d        = '1;
            cnt_d        = '0;
            state_d      = IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_q       <= '0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      crc_q        <= '1;
      in_frame_q   <= 1'b0;
      frame_crc_q  <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      crc_q        <= crc_d;
      in_frame_q   <= in_frame_d;
      frame_crc_q  <= frame_crc_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign m_dibit    = dib;
  assign frame_crc  = frame_crc_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_crc2bit_framer.sv
// Scoreboard bench for crc2bit_framer: expected beats and frame CRCs are queued
// when bytes are accepted and compared as the DUT emits them.
module tb_crc2bit_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [1:0] m_dibit;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;
  logic [5:0] frame_crc;
  logic       frame_done;

  crc2bit_framer dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .m_dibit    (m_dibit),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .frame_crc  (frame_crc),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] d;
    logic       l;
  } beat_t;

  beat_t      exp_q[$];
  logic [5:0] crc_exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;
  int         run_len = 0;
  int         last_run_len = 0;
  bit         rand_ready = 0;
  bit         stall_prev = 0;
  logic [1:0] stall_d;
  logic       stall_l;
  bit         last_acc = 0;
  logic [5:0] mcrc = 6'h3F;

  // Bit-serial LFSR, MSB of the dibit shifted in first.
  function automatic logic [5:0] model_step(input logic [5:0] q, input logic [1:0] d);
    logic [5:0] r;
    logic fb;
    r = q;
    for (int i = 1; i >= 0; i--) begin
      fb = r[5] ^ d[i];
      r  = {r[4:0], 1'b0};
      if (fb) r = r ^ 6'h2F;
    end
    return r;
  endfunction

  task automatic tick();
    beat_t b;
    @(negedge clk);
    last_acc = (s_valid === 1'b1) && (s_ready === 1'b1);
    if (stall_prev) begin
      total++;
      if (m_valid !== 1'b1 || m_dibit !== stall_d || m_last !== stall_l) begin
        bad++;
        $display("FAIL stall_hold: got v=%b d=%b l=%b want v=1 d=%b l=%b",
                 m_valid, m_dibit, m_last, stall_d, stall_l);
      end
    end
    if (m_valid !== 1'b1) begin
      run_len = 0;
    end else if (m_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected: got d=%b l=%b want no beat", m_dibit, m_last);
      end else begin
        b = exp_q.pop_front();
        if (m_dibit !== b.d || m_last !== b.l) begin
          bad++;
          $display("FAIL beat: got d=%b l=%b want d=%b l=%b", m_dibit, m_last, b.d, b.l);
        end
      end
      run_len++;
      if (m_last === 1'b1) begin
        last_run_len = run_len;
        run_len = 0;
      end
    end
    if (frame_done === 1'b1) begin
      total++;
      done_cnt++;
      if (crc_exp_q.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected: got frame_done=1 crc=%h want no pulse", frame_crc);
      end else if (frame_crc !== crc_exp_q[0]) begin
        bad++;
        $display("FAIL frame_crc: got %h want %h", frame_crc, crc_exp_q[0]);
        void'(crc_exp_q.pop_front());
      end else begin
        void'(crc_exp_q.pop_front());
      end
    end
    stall_prev = (m_valid === 1'b1) && (m_ready === 1'b0);
    stall_d    = m_dibit;
    stall_l    = m_last;
    @(posedge clk);
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    logic [1:0] dib;
    for (int i = 0; i < 4; i++) begin
      dib = 2'(d >> (6 - 2 * i));
      exp_q.push_back('{d: dib, l: 1'b0});
      mcrc = model_step(mcrc, dib);
    end
    if (l) begin
      exp_q.push_back('{d: mcrc[5:4], l: 1'b0});
      exp_q.push_back('{d: mcrc[3:2], l: 1'b0});
      exp_q.push_back('{d: mcrc[1:0], l: 1'b1});
      crc_exp_q.push_back(mcrc);
      mcrc = 6'h3F;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, output int waited);
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    waited  = 0;
    last_acc = 0;
    while (!last_acc && waited < 300) begin
      tick();
      waited++;
    end
    if (!last_acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept in %0d cycles want accept", waited);
    end else begin
      push_byte(d, l);
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while ((exp_q.size() != 0 || crc_exp_q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || crc_exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d beats %0d crcs pending want 0",
               exp_q.size(), crc_exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    #1;
    total++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || s_ready !== 1'b1 ||
        frame_crc !== 6'h3F || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got v=%b l=%b rdy=%b crc=%h done=%b want 0 0 1 3f 0",
               m_valid, m_last, s_ready, frame_crc, frame_done);
    end
    @(posedge clk); #1; rst = 1'b0;
    tick();
    total++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || frame_crc !== 6'h3F) begin
      bad++;
      $display("FAIL post_reset_idle: got v=%b rdy=%b crc=%h want 0 1 3f",
               m_valid, s_ready, frame_crc);
    end
  endtask

  task automatic test_single_zero();
    int w, d0;
    d0 = done_cnt;
    send_byte(8'h00, 1'b1, w);
    wait_end();
    total++;
    if (frame_crc !== 6'h36 || done_cnt != d0 + 1 || last_run_len != 7) begin
      bad++;
      $display("FAIL single_zero: got crc=%h dones=%0d run=%0d want 36 1 7",
               frame_crc, done_cnt - d0, last_run_len);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    send_byte(8'hA5, 1'b0, w);
    send_byte(8'h3C, 1'b1, w);
    wait_end();
    total++;
    if (last_run_len != 11) begin
      bad++;
      $display("FAIL back_to_back_beats: got run=%0d want 11", last_run_len);
    end
  endtask

  task automatic test_random_ready();
    int w, d0;
    d0 = done_cnt;
    rand_ready = 1;
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), (i == 15), w);
    wait_end();
    rand_ready = 0;
    total++;
    if (done_cnt != d0 + 1) begin
      bad++;
      $display("FAIL random_ready_done: got %0d pulses want 1", done_cnt - d0);
    end
  endtask

  task automatic test_gap();
    int w;
    logic [5:0] ref_crc;
    ref_crc = 6'h3F;
    for (int i = 0; i < 4; i++) ref_crc = model_step(ref_crc, 2'(8'h5A >> (6 - 2 * i)));
    for (int i = 0; i < 4; i++) ref_crc = model_step(ref_crc, 2'(8'hC3 >> (6 - 2 * i)));
    send_byte(8'h5A, 1'b0, w);
    send_byte(8'hC3, 1'b1, w);
    wait_end();
    send_byte(8'h5A, 1'b0, w);
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL gap_idle: got v=%b rdy=%b want 0 1", m_valid, s_ready);
    end
    send_byte(8'hC3, 1'b1, w);
    wait_end();
    total++;
    if (frame_crc !== ref_crc) begin
      bad++;
      $display("FAIL gap_crc: got %h want %h", frame_crc, ref_crc);
    end
  endtask

  task automatic test_two_frames();
    int w, d0;
    d0 = done_cnt;
    send_byte(8'h00, 1'b1, w);
    send_byte(8'h00, 1'b1, w);
    total++;
    if (w != 8) begin
      bad++;
      $display("FAIL next_frame_accept: got %0d cycles want 8", w);
    end
    wait_end();
    total++;
    if (frame_crc !== 6'h36 || done_cnt != d0 + 2) begin
      bad++;
      $display("FAIL two_frames: got crc=%h dones=%0d want 36 2", frame_crc, done_cnt - d0);
    end
  endtask

  task automatic test_async_reset();
    int w, d0;
    send_byte(8'h00, 1'b1, w);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_last !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got v=%b rdy=%b l=%b want 0 1 0", m_valid, s_ready, m_last);
    end
    exp_q.delete();
    crc_exp_q.delete();
    mcrc = 6'h3F;
    stall_prev = 0;
    d0 = done_cnt;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (done_cnt != d0 || m_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_drop: got dones=%0d v=%b want 0 0", done_cnt - d0, m_valid);
    end
    send_byte(8'h00, 1'b1, w);
    wait_end();
    total++;
    if (frame_crc !== 6'h36) begin
      bad++;
      $display("FAIL after_reset_crc: got %h want 36", frame_crc);
    end
  endtask

  initial begin
    test_reset();
    test_single_zero();
    test_back_to_back();
    test_random_ready();
    test_gap();
    test_two_frames();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
